fetch_controller: RTL

Sequences the 512x8 byte-addressed instruction ROM, which returns a 32-bit big-endian word combinationally from a 9-bit address. Maintains the SPARC PC/nPC pair with delayed-branch semantics and registers one instruction per cycle to decode. Shares the single ROM address port with a debug/loader read requester through a fetch-priority arbiter with a starvation guard. Sits between the ROM and the IF/ID pipeline register.

---
 rtl/fetch_pkg.sv | 11 +
 rtl/pc_npc_reg.sv | 44 ++++
 rtl/fetch_controller.sv | 162 ++++++++++++++++
 3 files changed

// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch controller.
package fetch_pkg;

    localparam int unsigned ADDR_W      = 9;
    localparam int unsigned DATA_W      = 32;
    localparam int unsigned INSTR_BYTES = 4;
    localparam int unsigned RESET_PC    = 0;

    typedef enum logic [1:0] {FETCH, DBG, ERROR} fetch_state_e;

endpackage

// File: rtl/pc_npc_reg.sv
// SPARC PC/nPC pair: hold, advance with delayed-branch redirect, modulo-2^ADDR_W increment.
module pc_npc_reg #(
    parameter int unsigned ADDR_W   = fetch_pkg::ADDR_W,
    parameter int unsigned RESET_PC = fetch_pkg::RESET_PC
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              advance,
    input  logic              redirect_valid,
    input  logic [ADDR_W-1:0] redirect_addr,
    output logic [ADDR_W-1:0] pc,
    output logic [ADDR_W-1:0] npc
);
    import fetch_pkg::*;

    localparam logic [ADDR_W-1:0] PcInit = ADDR_W'(RESET_PC);
    localparam logic [ADDR_W-1:0] Step   = ADDR_W'(INSTR_BYTES);

    logic [ADDR_W-1:0] pc_q, pc_d, npc_q, npc_d;

    // The redirect lands in nPC, so the instruction already at nPC is the delay slot.
    always_comb begin
        pc_d  = pc_q;
        npc_d = npc_q;
        if (advance) begin
            pc_d  = npc_q;
            npc_d = redirect_valid ? redirect_addr : npc_q + Step;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pc_q  <= PcInit;
            npc_q <= PcInit + Step;
        end else begin
            pc_q  <= pc_d;
            npc_q <= npc_d;
        end
    end

    assign pc  = pc_q;
    assign npc = npc_q;

endmodule

// File: rtl/fetch_controller.sv
// Instruction fetch sequencer sharing the ROM port with a debug reader.
// Optional counters fetch_count/dbg_forced_count are built when FETCH_PERF_EN is defined.
module fetch_controller #(
    parameter int unsigned ADDR_W     = fetch_pkg::ADDR_W,
    parameter int unsigned DATA_W     = fetch_pkg::DATA_W,
    parameter int unsigned RESET_PC   = fetch_pkg::RESET_PC,
    parameter int unsigned STARVE_MAX = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              stall,
    input  logic              redirect_valid,
    input  logic [ADDR_W-1:0] redirect_addr,
    input  logic              dbg_req,
    input  logic [ADDR_W-1:0] dbg_addr,
    output logic [ADDR_W-1:0] rom_addr,
    input  logic [DATA_W-1:0] rom_data,
    output logic [DATA_W-1:0] instr_out,
    output logic [ADDR_W-1:0] instr_pc,
    output logic              instr_valid,
    output logic              dbg_valid,
    output logic [DATA_W-1:0] dbg_data,
`ifdef FETCH_PERF_EN
    output logic [31:0]       fetch_count,
    output logic [15:0]       dbg_forced_count,
`endif
    output logic              align_err
);
    import fetch_pkg::*;

    localparam logic [3:0] StarveMax = 4'(STARVE_MAX);

    fetch_state_e      state_q, state_d;
    logic [3:0]        starve_q, starve_d;
    logic [DATA_W-1:0] instr_out_q, instr_out_d, dbg_data_q, dbg_data_d;
    logic [ADDR_W-1:0] instr_pc_q, instr_pc_d;
    logic              instr_valid_q, instr_valid_d;
    logic              dbg_valid_q, dbg_valid_d;
    logic              align_q, align_d;

    logic [ADDR_W-1:0] pc, npc;
    logic              pc_mis, dbg_mis, grant, advance;

    assign pc_mis  = (pc[1:0] != 2'b00);
    assign dbg_mis = (dbg_addr[1:0] != 2'b00);
    assign grant   = (state_q == FETCH) && !pc_mis && dbg_req &&
                     (stall || (starve_q == StarveMax));
    assign advance = (state_q == FETCH) && !pc_mis && !stall;

    pc_npc_reg #(
        .ADDR_W   (ADDR_W),
        .RESET_PC (RESET_PC)
    ) u_pc_npc_reg (
        .clk            (clk),
        .reset          (reset),
        .advance        (advance),
        .redirect_valid (redirect_valid),
        .redirect_addr  (redirect_addr),
        .pc             (pc),
        .npc            (npc)
    );

    always_comb begin
        state_d       = state_q;
        starve_d      = '0;
        rom_addr      = pc;
        instr_out_d   = instr_out_q;
        instr_pc_d    = instr_pc_q;
        instr_valid_d = instr_valid_q;
        dbg_valid_d   = 1'b0;
        dbg_data_d    = dbg_data_q;
        align_d       = align_q;
        unique case (state_q)
            FETCH: begin
                if (pc_mis) begin
                    align_d       = 1'b1;
                    instr_valid_d = 1'b0;
                    state_d       = ERROR;
                end else begin
                    // A forced grant with stall=0 still fetches this cycle; the bubble is the DBG cycle.
                    if (!stall) begin
                        instr_out_d   = rom_data;
                        instr_pc_d    = pc;
                        instr_valid_d = 1'b1;
                    end
                    if (grant) begin
                        state_d = DBG;
                    end else if (dbg_req) begin
                        starve_d = (starve_q == StarveMax) ? starve_q : starve_q + 4'd1;
                    end
                end
            end
            DBG: begin
                rom_addr = dbg_addr;
                if (!stall) instr_valid_d = 1'b0;
                if (dbg_mis) begin
                    align_d       = 1'b1;
                    instr_valid_d = 1'b0;
                    state_d       = ERROR;
                end else begin
                    dbg_valid_d = 1'b1;
                    dbg_data_d  = rom_data;
                    state_d     = FETCH;
                end
            end
            ERROR: begin
                instr_valid_d = 1'b0;
            end
            default: begin
                state_d = FETCH;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= FETCH;
            starve_q      <= '0;
            instr_out_q   <= '0;
            instr_pc_q    <= '0;
            instr_valid_q <= 1'b0;
            dbg_valid_q   <= 1'b0;
            dbg_data_q    <= '0;
            align_q       <= 1'b0;
        end else begin
            state_q       <= state_d;
            starve_q      <= starve_d;
            instr_out_q   <= instr_out_d;
            instr_pc_q    <= instr_pc_d;
            instr_valid_q <= instr_valid_d;
            dbg_valid_q   <= dbg_valid_d;
            dbg_data_q    <= dbg_data_d;
            align_q       <= align_d;
        end
    end

    assign instr_out   = instr_out_q;
    assign instr_pc    = instr_pc_q;
    assign instr_valid = instr_valid_q;
    assign dbg_valid   = dbg_valid_q;
    assign dbg_data    = dbg_data_q;
    assign align_err   = align_q;

`ifdef FETCH_PERF_EN
    logic [31:0] fetch_count_q;
    logic [15:0] forced_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            fetch_count_q <= '0;
            forced_q      <= '0;
        end else begin
            if (advance) fetch_count_q <= fetch_count_q + 32'd1;
            if (grant && !stall) forced_q <= forced_q + 16'd1;
        end
    end

    assign fetch_count      = fetch_count_q;
    assign dbg_forced_count = forced_q;
`endif

endmodule
